// File: rtl/tcm_mem_pkg.sv
// Shared constants for the tightly-coupled memory: geometry, tag width and base address.
package tcm_mem_pkg;
  localparam int TCM_WORDS  = 16384;
  localparam int TCM_ADDR_W = 14;
  localparam int TAG_W      = 11;
  localparam logic [31:0] TCM_BASE = 32'h8000_0000;

  // The window is 128 KiB aligned, so a compare of the bits above [16:0] is enough.
  function automatic logic in_tcm_range(input logic [31:0] addr);
    return addr[31:17] == TCM_BASE[31:17];
  endfunction
endpackage

// File: rtl/tcm_mem_ram.sv
// Dual-port 64-bit RAM: port A read-only (fetch), port B read/write with byte enables.
// Both ports are read-first; contents are never reset.
module tcm_mem_ram
  import tcm_mem_pkg::*;
(
  input  logic                  clk,
  input  logic [TCM_ADDR_W-1:0] addr_a,
  output logic [63:0]           rdata_a,
  input  logic [TCM_ADDR_W-1:0] addr_b,
  input  logic [7:0]            be_b,
  input  logic [63:0]           wdata_b,
  output logic [63:0]           rdata_b
);

  logic [63:0] ram [TCM_WORDS];

  always @(posedge clk) begin
    rdata_a <= ram[addr_a];
    rdata_b <= ram[addr_b];
    for (int i = 0; i < 8; i++) begin
      if (be_b[i]) ram[addr_b][i*8 +: 8] <= wdata_b[i*8 +: 8];
    end
  end

  // Image preload hook; takes effect in the current time step.
  task automatic write_byte(input logic [TCM_ADDR_W-1:0] idx, input logic [2:0] lane,
                            input logic [7:0] val);
    ram[idx][{lane, 3'b000} +: 8] <= val;
  endtask

endmodule

// File: rtl/tcm_mem.sv
// Single-cycle TCM with an instruction fetch port and a tagged data port, no stalls.
// Optional macro TCM_MEM_RANGE_CHECK_EN flags accesses outside the 128 KiB window.
module tcm_mem
  import tcm_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_i_rd_i,
  input  logic             mem_i_flush_i,
  input  logic             mem_i_invalidate_i,
  input  logic [31:0]      mem_i_pc_i,
  output logic             mem_i_accept_o,
  output logic             mem_i_valid_o,
  output logic             mem_i_error_o,
  output logic [63:0]      mem_i_inst_o,
  input  logic [31:0]      mem_d_addr_i,
  input  logic [31:0]      mem_d_data_wr_i,
  input  logic             mem_d_rd_i,
  input  logic [3:0]       mem_d_wr_i,
  input  logic             mem_d_cacheable_i,
  input  logic [TAG_W-1:0] mem_d_req_tag_i,
  input  logic             mem_d_invalidate_i,
  input  logic             mem_d_writeback_i,
  input  logic             mem_d_flush_i,
  output logic             mem_d_accept_o,
  output logic             mem_d_ack_o,
  output logic             mem_d_error_o,
  output logic [TAG_W-1:0] mem_d_resp_tag_o,
  output logic [31:0]      mem_d_data_rd_o
);

  logic             d_req;
  logic             i_ok;
  logic             d_ok;
  logic [7:0]       be;
  logic [63:0]      rdata_a;
  logic [63:0]      rdata_b;
  logic             valid_d, valid_q;
  logic             ack_d, ack_q;
  logic             hi_d, hi_q;
  logic [TAG_W-1:0] tag_d, tag_q;
  logic             i_err_q, d_err_q;
  logic             unused_ok;

  assign mem_i_accept_o = 1'b1;
  assign mem_d_accept_o = 1'b1;

  assign d_req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_cacheable_i | mem_d_invalidate_i
               | mem_d_writeback_i | mem_d_flush_i;

`ifdef TCM_MEM_RANGE_CHECK_EN
  logic i_err_d, d_err_d;

  assign i_ok = in_tcm_range(mem_i_pc_i);
  assign d_ok = in_tcm_range(mem_d_addr_i);

  always_comb begin
    i_err_d = mem_i_rd_i & ~i_ok;
    d_err_d = d_req & ~d_ok;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      i_err_q <= i_err_d;
      d_err_q <= d_err_d;
    end
  end
`else
  assign i_ok    = 1'b1;
  assign d_ok    = 1'b1;
  assign i_err_q = 1'b0;
  assign d_err_q = 1'b0;
`endif

  always_comb begin
    valid_d = mem_i_rd_i;
    ack_d   = d_req;
    hi_d    = hi_q;
    tag_d   = tag_q;
    be      = 8'h00;
    if (d_req) begin
      hi_d  = mem_d_addr_i[2];
      tag_d = mem_d_req_tag_i;
    end
    if (d_ok) be = mem_d_addr_i[2] ? {mem_d_wr_i, 4'h0} : {4'h0, mem_d_wr_i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      hi_q    <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ack_q   <= ack_d;
      hi_q    <= hi_d;
      tag_q   <= tag_d;
    end
  end

  tcm_mem_ram u_ram (
    .clk     (clk),
    .addr_a  (mem_i_pc_i[16:3]),
    .rdata_a (rdata_a),
    .addr_b  (mem_d_addr_i[16:3]),
    .be_b    (be),
    .wdata_b ({mem_d_data_wr_i, mem_d_data_wr_i}),
    .rdata_b (rdata_b)
  );

  // RAM read registers are not reset, so outputs are gated by the response strobes.
  assign mem_i_valid_o    = valid_q;
  assign mem_i_error_o    = i_err_q;
  assign mem_i_inst_o     = (valid_q && !i_err_q) ? rdata_a : 64'h0;
  assign mem_d_ack_o      = ack_q;
  assign mem_d_error_o    = d_err_q;
  assign mem_d_resp_tag_o = tag_q;
  assign mem_d_data_rd_o  = (ack_q && !d_err_q) ? (hi_q ? rdata_b[63:32] : rdata_b[31:0])
                                                : 32'h0;

  assign unused_ok = ^{mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i[31:17], mem_i_pc_i[2:0],
                       mem_d_addr_i[31:17], mem_d_addr_i[1:0]};

  task automatic write(input logic [31:0] addr, input logic [7:0] val);
    u_ram.write_byte(addr[16:3], addr[2:0], val);
  endtask

endmodule

// File: tb/tb_tcm_mem.sv
// Self-checking bench for tcm_mem: directed scenarios plus randomized traffic against a byte-array model.
module tb_tcm_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i;
  logic [31:0] mem_i_pc_i;
  logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
  logic [63:0] mem_i_inst_o;
  logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
  logic        mem_d_rd_i;
  logic [3:0]  mem_d_wr_i;
  logic        mem_d_cacheable_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i;
  logic [10:0] mem_d_req_tag_i;
  logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
  logic [10:0] mem_d_resp_tag_o;
  logic [31:0] mem_d_data_rd_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mdl [512];

  always #5 clk = ~clk;

  tcm_mem dut (
    .clk(clk), .rst(rst),
    .mem_i_rd_i(mem_i_rd_i), .mem_i_flush_i(mem_i_flush_i),
    .mem_i_invalidate_i(mem_i_invalidate_i), .mem_i_pc_i(mem_i_pc_i),
    .mem_i_accept_o(mem_i_accept_o), .mem_i_valid_o(mem_i_valid_o),
    .mem_i_error_o(mem_i_error_o), .mem_i_inst_o(mem_i_inst_o),
    .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
    .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i),
    .mem_d_cacheable_i(mem_d_cacheable_i), .mem_d_req_tag_i(mem_d_req_tag_i),
    .mem_d_invalidate_i(mem_d_invalidate_i), .mem_d_writeback_i(mem_d_writeback_i),
    .mem_d_flush_i(mem_d_flush_i), .mem_d_accept_o(mem_d_accept_o),
    .mem_d_ack_o(mem_d_ack_o), .mem_d_error_o(mem_d_error_o),
    .mem_d_resp_tag_o(mem_d_resp_tag_o), .mem_d_data_rd_o(mem_d_data_rd_o)
  );

  task automatic idle();
    mem_i_rd_i = 0; mem_i_flush_i = 0; mem_i_invalidate_i = 0; mem_i_pc_i = 32'h8000_0000;
    mem_d_addr_i = 32'h8000_0000; mem_d_data_wr_i = 0; mem_d_rd_i = 0; mem_d_wr_i = 0;
    mem_d_cacheable_i = 0; mem_d_invalidate_i = 0; mem_d_writeback_i = 0; mem_d_flush_i = 0;
    mem_d_req_tag_i = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    @(negedge clk);
    mem_i_rd_i = 1; mem_d_rd_i = 1; mem_d_req_tag_i = 11'h5a5;
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_i_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0h exp=0", mem_i_valid_o); end
    n_cmp++; if (mem_d_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%0h exp=0", mem_d_ack_o); end
    n_cmp++; if (mem_d_resp_tag_o !== 11'h0) begin n_bad++; $display("FAIL reset_tag got=%0h exp=0", mem_d_resp_tag_o); end
    n_cmp++; if (mem_d_data_rd_o !== 32'h0) begin n_bad++; $display("FAIL reset_data got=%0h exp=0", mem_d_data_rd_o); end
    n_cmp++; if (mem_i_inst_o !== 64'h0) begin n_bad++; $display("FAIL reset_inst got=%0h exp=0", mem_i_inst_o); end
    n_cmp++; if ({mem_i_error_o, mem_d_error_o} !== 2'b00) begin n_bad++; $display("FAIL reset_err got=%0b exp=00", {mem_i_error_o, mem_d_error_o}); end
    n_cmp++; if ({mem_i_accept_o, mem_d_accept_o} !== 2'b11) begin n_bad++; $display("FAIL accept got=%0b exp=11", {mem_i_accept_o, mem_d_accept_o}); end
    idle();
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_preload_fetch();
    dut.write(32'h0, 8'h13);
    @(negedge clk);
    mem_i_pc_i = 32'h8000_0000; mem_i_rd_i = 1;
    @(negedge clk);
    idle();
    n_cmp++; if (mem_i_valid_o !== 1'b1) begin n_bad++; $display("FAIL fetch_valid got=%0h exp=1", mem_i_valid_o); end
    n_cmp++; if (mem_i_inst_o[7:0] !== 8'h13) begin n_bad++; $display("FAIL fetch_preload got=%0h exp=13", mem_i_inst_o[7:0]); end
    @(negedge clk);
    n_cmp++; if (mem_i_valid_o !== 1'b0) begin n_bad++; $display("FAIL fetch_valid_drop got=%0h exp=0", mem_i_valid_o); end
  endtask

  task automatic test_word_write();
    logic [10:0] tg;
    tg = 11'($urandom);
    for (int b = 0; b < 16; b++) dut.write(32'h9000 + b, 8'h00);
    @(negedge clk);
    mem_d_addr_i = 32'h8000_9000; mem_d_wr_i = 4'hF; mem_d_data_wr_i = 32'h600D_0001;
    mem_d_req_tag_i = tg;
    @(negedge clk);
    idle();
    n_cmp++; if (mem_d_ack_o !== 1'b1) begin n_bad++; $display("FAIL wr_ack got=%0h exp=1", mem_d_ack_o); end
    n_cmp++; if (mem_d_resp_tag_o !== tg) begin n_bad++; $display("FAIL wr_tag got=%0h exp=%0h", mem_d_resp_tag_o, tg); end
    n_cmp++; if (dut.u_ram.ram[14'h1200] !== 64'h0000_0000_600D_0001) begin n_bad++; $display("FAIL wr_ram got=%0h exp=600d0001", dut.u_ram.ram[14'h1200]); end
    @(negedge clk);
    n_cmp++; if (mem_d_ack_o !== 1'b0) begin n_bad++; $display("FAIL wr_ack_once got=%0h exp=0", mem_d_ack_o); end
  endtask

  task automatic test_byte_write();
    @(negedge clk);
    mem_d_addr_i = 32'h8000_9004; mem_d_wr_i = 4'h2; mem_d_data_wr_i = 32'hAABB_CCDD;
    mem_d_req_tag_i = 11'h001;
    @(negedge clk);
    n_cmp++; if (mem_d_ack_o !== 1'b1) begin n_bad++; $display("FAIL bwr_ack got=%0h exp=1", mem_d_ack_o); end
    idle();
    mem_d_addr_i = 32'h8000_9004; mem_d_rd_i = 1; mem_d_req_tag_i = 11'h002;
    @(negedge clk);
    idle();
    n_cmp++; if (mem_d_resp_tag_o !== 11'h002) begin n_bad++; $display("FAIL bwr_rd_tag got=%0h exp=2", mem_d_resp_tag_o); end
    n_cmp++; if (mem_d_data_rd_o !== 32'h0000_CC00) begin n_bad++; $display("FAIL bwr_rd_data got=%0h exp=0000cc00", mem_d_data_rd_o); end
  endtask

  task automatic test_read_first();
    for (int b = 0; b < 8; b++) dut.write(32'h9008 + b, 8'(8'h11 * (b + 1)));
    @(negedge clk);
    mem_i_pc_i = 32'h8000_9008; mem_i_rd_i = 1;
    mem_d_addr_i = 32'h8000_9008; mem_d_wr_i = 4'hF; mem_d_data_wr_i = 32'hDEAD_BEEF;
    @(negedge clk);
    idle();
    mem_i_pc_i = 32'h8000_900B; mem_i_rd_i = 1;
    n_cmp++; if (mem_i_inst_o !== 64'h8877_6655_4433_2211) begin n_bad++; $display("FAIL rf_old got=%0h exp=8877665544332211", mem_i_inst_o); end
    @(negedge clk);
    idle();
    n_cmp++; if (mem_i_inst_o !== 64'h8877_6655_DEAD_BEEF) begin n_bad++; $display("FAIL rf_new got=%0h exp=88776655deadbeef", mem_i_inst_o); end
  endtask

  task automatic test_rd_wr_combo();
    @(negedge clk);
    mem_d_addr_i = 32'h8000_9008; mem_d_rd_i = 1; mem_d_wr_i = 4'hF;
    mem_d_data_wr_i = 32'h1234_5678; mem_d_req_tag_i = 11'h003;
    @(negedge clk);
    idle();
    n_cmp++; if (mem_d_data_rd_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rw_old got=%0h exp=deadbeef", mem_d_data_rd_o); end
    @(negedge clk);
    n_cmp++; if (mem_d_ack_o !== 1'b0) begin n_bad++; $display("FAIL rw_ack_once got=%0h exp=0", mem_d_ack_o); end
    mem_d_addr_i = 32'h8000_900B; mem_d_rd_i = 1;
    @(negedge clk);
    idle();
    n_cmp++; if (mem_d_data_rd_o !== 32'h1234_5678) begin n_bad++; $display("FAIL rw_new got=%0h exp=12345678", mem_d_data_rd_o); end
  endtask

  task automatic test_reset_midread();
    @(negedge clk);
    mem_d_addr_i = 32'h8000_900C; mem_d_rd_i = 1; mem_d_req_tag_i = 11'h007;
    @(posedge clk);
    #1;
    rst = 0;
    idle();
    #1;
    n_cmp++; if ({mem_d_ack_o, mem_i_valid_o} !== 2'b00) begin n_bad++; $display("FAIL rst_mid_ack got=%0b exp=00", {mem_d_ack_o, mem_i_valid_o}); end
    n_cmp++; if (mem_d_data_rd_o !== 32'h0) begin n_bad++; $display("FAIL rst_mid_data got=%0h exp=0", mem_d_data_rd_o); end
    n_cmp++; if (mem_d_resp_tag_o !== 11'h0) begin n_bad++; $display("FAIL rst_mid_tag got=%0h exp=0", mem_d_resp_tag_o); end
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    n_cmp++; if (mem_d_ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_post_ack got=%0h exp=0", mem_d_ack_o); end
    mem_d_addr_i = 32'h8000_900C; mem_d_rd_i = 1; mem_d_req_tag_i = 11'h008;
    mem_i_pc_i = 32'h8000_0000; mem_i_rd_i = 1;
    @(negedge clk);
    idle();
    n_cmp++; if (mem_d_data_rd_o !== 32'h8877_6655) begin n_bad++; $display("FAIL rst_keep_data got=%0h exp=88776655", mem_d_data_rd_o); end
    n_cmp++; if (mem_i_inst_o[7:0] !== 8'h13) begin n_bad++; $display("FAIL rst_keep_inst got=%0h exp=13", mem_i_inst_o[7:0]); end
  endtask

  task automatic test_back_to_back();
    logic        exp_v, exp_ack, exp_rd;
    logic [63:0] exp_inst;
    logic [31:0] exp_data;
    logic [10:0] exp_tag;
    int          p_off, a_off, pw, ab;
    for (int b = 0; b < 512; b++) begin
      dut.write(32'h4000 + b, 8'h00);
      mdl[b] = 8'h00;
    end
    exp_v = 0; exp_ack = 0; exp_rd = 0; exp_inst = 0; exp_data = 0; exp_tag = 0;
    for (int n = 0; n <= 400; n++) begin
      @(negedge clk);
      if (n > 0) begin
        n_cmp++; if (mem_i_valid_o !== exp_v) begin n_bad++; $display("FAIL b2b_valid n=%0d got=%0h exp=%0h", n, mem_i_valid_o, exp_v); end
        if (exp_v) begin
          n_cmp++; if (mem_i_inst_o !== exp_inst) begin n_bad++; $display("FAIL b2b_inst n=%0d got=%0h exp=%0h", n, mem_i_inst_o, exp_inst); end
        end
        n_cmp++; if (mem_d_ack_o !== exp_ack) begin n_bad++; $display("FAIL b2b_ack n=%0d got=%0h exp=%0h", n, mem_d_ack_o, exp_ack); end
        if (exp_ack) begin
          n_cmp++; if (mem_d_resp_tag_o !== exp_tag) begin n_bad++; $display("FAIL b2b_tag n=%0d got=%0h exp=%0h", n, mem_d_resp_tag_o, exp_tag); end
        end
        if (exp_rd) begin
          n_cmp++; if (mem_d_data_rd_o !== exp_data) begin n_bad++; $display("FAIL b2b_data n=%0d got=%0h exp=%0h", n, mem_d_data_rd_o, exp_data); end
        end
      end
      if (n == 400) break;
      idle();
      p_off = int'($urandom_range(0, 511));
      a_off = int'($urandom_range(0, 511));
      mem_i_rd_i = 1'($urandom);
      mem_i_flush_i = ($urandom_range(0, 7) == 0);
      mem_i_pc_i = 32'h8000_4000 + 32'(p_off);
      mem_d_addr_i = 32'h8000_4000 + 32'(a_off);
      mem_d_rd_i = 1'($urandom);
      mem_d_wr_i = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      mem_d_data_wr_i = $urandom;
      mem_d_req_tag_i = 11'($urandom);
      mem_d_flush_i = ($urandom_range(0, 9) == 0);
      mem_d_cacheable_i = ($urandom_range(0, 9) == 0);
      pw = p_off & 'h1F8;
      ab = a_off & 'h1FC;
      exp_v = mem_i_rd_i;
      for (int k = 0; k < 8; k++) exp_inst[k*8 +: 8] = mdl[pw + k];
      for (int k = 0; k < 4; k++) exp_data[k*8 +: 8] = mdl[ab + k];
      exp_ack = mem_d_rd_i | (mem_d_wr_i != 0) | mem_d_flush_i | mem_d_cacheable_i;
      exp_rd = mem_d_rd_i;
      exp_tag = mem_d_req_tag_i;
      for (int k = 0; k < 4; k++) if (mem_d_wr_i[k]) mdl[ab + k] = mem_d_data_wr_i[k*8 +: 8];
    end
    idle();
  endtask

  task automatic test_range();
    @(negedge clk);
    mem_d_addr_i = 32'h9000_9000; mem_d_wr_i = 4'hF; mem_d_data_wr_i = 32'hFFFF_FFFF;
    @(negedge clk);
    idle();
    mem_d_addr_i = 32'h9000_9000; mem_d_rd_i = 1; mem_d_req_tag_i = 11'h009;
    mem_i_pc_i = 32'h9000_9000; mem_i_rd_i = 1;
    @(negedge clk);
    idle();
    mem_d_addr_i = 32'h8000_9000; mem_d_rd_i = 1;
    n_cmp++; if (mem_d_ack_o !== 1'b1) begin n_bad++; $display("FAIL rng_ack got=%0h exp=1", mem_d_ack_o); end
    n_cmp++; if (mem_i_valid_o !== 1'b1) begin n_bad++; $display("FAIL rng_valid got=%0h exp=1", mem_i_valid_o); end
`ifdef TCM_MEM_RANGE_CHECK_EN
    n_cmp++; if (mem_d_error_o !== 1'b1) begin n_bad++; $display("FAIL rng_derr got=%0h exp=1", mem_d_error_o); end
    n_cmp++; if (mem_d_data_rd_o !== 32'h0) begin n_bad++; $display("FAIL rng_data got=%0h exp=0", mem_d_data_rd_o); end
    n_cmp++; if (mem_i_error_o !== 1'b1) begin n_bad++; $display("FAIL rng_ierr got=%0h exp=1", mem_i_error_o); end
    n_cmp++; if (mem_i_inst_o !== 64'h0) begin n_bad++; $display("FAIL rng_inst got=%0h exp=0", mem_i_inst_o); end
    @(negedge clk);
    idle();
    n_cmp++; if (mem_d_data_rd_o !== 32'h600D_0001) begin n_bad++; $display("FAIL rng_wr_blocked got=%0h exp=600d0001", mem_d_data_rd_o); end
`else
    n_cmp++; if (mem_d_error_o !== 1'b0) begin n_bad++; $display("FAIL wrap_derr got=%0h exp=0", mem_d_error_o); end
    n_cmp++; if (mem_d_data_rd_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_data got=%0h exp=ffffffff", mem_d_data_rd_o); end
    n_cmp++; if (mem_i_error_o !== 1'b0) begin n_bad++; $display("FAIL wrap_ierr got=%0h exp=0", mem_i_error_o); end
    n_cmp++; if (mem_i_inst_o !== 64'h0000_CC00_FFFF_FFFF) begin n_bad++; $display("FAIL wrap_inst got=%0h exp=0000cc00ffffffff", mem_i_inst_o); end
    @(negedge clk);
    idle();
    n_cmp++; if (mem_d_data_rd_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_wr got=%0h exp=ffffffff", mem_d_data_rd_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_preload_fetch();
    test_word_write();
    test_byte_write();
    test_read_first();
    test_rd_wr_combo();
    test_reset_midread();
    test_back_to_back();
    test_range();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
